// File: rtl/imm_extend_pipe_pkg.sv
// -----------------------------------------------------------------------------
// imm_ext_pkg
// Shared constants for the immediate-extension pipe: extension mode codes,
// mode select width and default immediate/output widths.
// No ports (package).
// -----------------------------------------------------------------------------
package imm_ext_pkg;

    // Width of the extension mode select
    localparam int MODE_W = 3;

    // Default widths: classic 16-bit immediate widened to a 32-bit datapath
    localparam int DEF_IN_W  = 16;
    localparam int DEF_OUT_W = 32;

    // Byte-mode source width
    localparam int BYTE_W = 8;

    // Extension modes; codes 6 and 7 are reserved and flag an error
    localparam int MODE_SEXT   = 0;
    localparam int MODE_ZEXT   = 1;
    localparam int MODE_UPPER  = 2;
    localparam int MODE_SEXT_B = 3;
    localparam int MODE_ZEXT_B = 4;
    localparam int MODE_BR_OFF = 5;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_ext_if
// Valid/ready bus between decode, the immediate-extension pipe and the
// ALU-source mux.
//   data_i/mode_i/valid_i/ready_o : upstream side (raw immediate + mode)
//   data_o/err_o/valid_o/ready_i  : downstream side (extended immediate)
// Modport slave is the pipe itself; master is whoever drives and consumes it.
// -----------------------------------------------------------------------------
interface imm_ext_if #(
    parameter int IN_W   = imm_ext_pkg::DEF_IN_W,
    parameter int OUT_W  = imm_ext_pkg::DEF_OUT_W,
    parameter int MODE_W = imm_ext_pkg::MODE_W
) ();

    logic [IN_W-1:0]   data_i;
    logic [MODE_W-1:0] mode_i;
    logic              valid_i;
    logic              ready_o;
    logic [OUT_W-1:0]  data_o;
    logic              err_o;
    logic              valid_o;
    logic              ready_i;

    modport master (
        output data_i, mode_i, valid_i, ready_i,
        input  ready_o, data_o, err_o, valid_o
    );

    modport slave (
        input  data_i, mode_i, valid_i, ready_i,
        output ready_o, data_o, err_o, valid_o
    );

endinterface

// File: rtl/imm_extend_pipe_core.sv
// -----------------------------------------------------------------------------
// imm_ext_core
// Purely combinational immediate extension.
//   data_i : raw immediate (IN_W)
//   mode_i : extension mode (MODE_W)
//   ext_o  : extended immediate (OUT_W), zero for reserved modes
//   err_o  : high when mode_i is reserved
// -----------------------------------------------------------------------------
module imm_ext_core #(
    parameter int IN_W   = imm_ext_pkg::DEF_IN_W,
    parameter int OUT_W  = imm_ext_pkg::DEF_OUT_W,
    parameter int MODE_W = imm_ext_pkg::MODE_W
) (
    input  logic [IN_W-1:0]   data_i,
    input  logic [MODE_W-1:0] mode_i,
    output logic [OUT_W-1:0]  ext_o,
    output logic              err_o
);
    import imm_ext_pkg::*;

    logic [OUT_W-1:0] w_sext;

    // Full-width sign extension is shared by SEXT and the branch offset
    assign w_sext = {{(OUT_W-IN_W){data_i[IN_W-1]}}, data_i};

    // Mode decode; any code outside the defined set yields zero with err_o set
    always_comb begin
        ext_o = '0;
        err_o = 1'b0;
        case (int'(mode_i))
            MODE_SEXT:   ext_o = w_sext;
            MODE_ZEXT:   ext_o = {{(OUT_W-IN_W){1'b0}}, data_i};
            MODE_UPPER:  ext_o = {data_i, {(OUT_W-IN_W){1'b0}}};
            MODE_SEXT_B: ext_o = {{(OUT_W-BYTE_W){data_i[BYTE_W-1]}}, data_i[BYTE_W-1:0]};
            MODE_ZEXT_B: ext_o = {{(OUT_W-BYTE_W){1'b0}}, data_i[BYTE_W-1:0]};
            // Word-aligned branch offset: top two bits of the SEXT result fall off
            MODE_BR_OFF: ext_o = {w_sext[OUT_W-3:0], 2'b00};
            default:     err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
// Pipelined immediate-extension unit with a 2-entry (output + skid) buffer.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : imm_ext_if.slave, upstream and downstream valid/ready handshake
// An extended immediate appears one cycle after acceptance when empty;
// ready_o depends only on the skid register, never on ready_i.
// -----------------------------------------------------------------------------
module imm_extend_pipe #(
    parameter int IN_W   = imm_ext_pkg::DEF_IN_W,
    parameter int OUT_W  = imm_ext_pkg::DEF_OUT_W,
    parameter int MODE_W = imm_ext_pkg::MODE_W
) (
    input  logic        clk_i,
    input  logic        rst_i,
    imm_ext_if.slave    bus
);

    logic [OUT_W-1:0] w_ext;
    logic             w_err;
    logic             w_accept;
    logic             w_drain;

    logic             r_orValid;
    logic [OUT_W-1:0] r_orData;
    logic             r_orErr;
    logic             r_skValid;
    logic [OUT_W-1:0] r_skData;
    logic             r_skErr;

    imm_ext_core #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .MODE_W (MODE_W)
    ) u_core (
        .data_i (bus.data_i),
        .mode_i (bus.mode_i),
        .ext_o  (w_ext),
        .err_o  (w_err)
    );

    // Accept only while the skid slot is free, so a stalled output never loses data
    assign bus.ready_o = ~r_skValid;
    assign w_accept    = bus.valid_i & ~r_skValid;
    assign w_drain     = r_orValid & bus.ready_i;

    // Output/skid register update. A drain refills OR from SK first (FIFO order);
    // accept+drain with SK full is impossible because ready_o is low then.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_orValid <= 1'b0;
            r_orData  <= '0;
            r_orErr   <= 1'b0;
            r_skValid <= 1'b0;
            r_skData  <= '0;
            r_skErr   <= 1'b0;
        end else if (w_drain) begin
            if (r_skValid) begin
                r_orData  <= r_skData;
                r_orErr   <= r_skErr;
                r_skValid <= 1'b0;
            end else if (w_accept) begin
                r_orData  <= w_ext;
                r_orErr   <= w_err;
            end else begin
                r_orValid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_orValid) begin
                r_orValid <= 1'b1;
                r_orData  <= w_ext;
                r_orErr   <= w_err;
            end else begin
                r_skValid <= 1'b1;
                r_skData  <= w_ext;
                r_skErr   <= w_err;
            end
        end
    end

    assign bus.valid_o = r_orValid;
    assign bus.data_o  = r_orData;
    assign bus.err_o   = r_orErr;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_extend_pipe
// Scoreboard bench for imm_extend_pipe: a 16->32 instance (A) and a 12->24
// instance (B). Stimulus pushes expected results; per-instance monitors pop and
// compare on every output transfer.
// -----------------------------------------------------------------------------
module tb_imm_extend_pipe;
    import imm_ext_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   popsA    = 0;
    int   popsB    = 0;
    int   tpDrops  = 0;
    bit   latCheck = 1'b0;
    bit   tpPhase  = 1'b0;
    bit   rndPhase = 1'b0;
    exp_t qA[$];
    exp_t qB[$];

    imm_ext_if #(.IN_W(16), .OUT_W(32), .MODE_W(3)) busA ();
    imm_ext_if #(.IN_W(12), .OUT_W(24), .MODE_W(3)) busB ();

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .MODE_W(3)) dutA (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (busA)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(24), .MODE_W(3)) dutB (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (busB)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: every check goes through here
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model from the extension rules, using plain integer arithmetic
    function automatic logic [31:0] model(input longint d, input int m, input int inW,
                                          input int outW, output logic err);
        longint full;
        longint v;
        longint b;
        full = longint'(1) << outW;
        err  = 1'b0;
        b    = d % 256;
        case (m)
            0: v = (d >= (longint'(1) << (inW-1))) ? d - (longint'(1) << inW) : d;
            1: v = d;
            2: v = d * (longint'(1) << (outW-inW));
            3: v = (b >= 128) ? b - 256 : b;
            4: v = b;
            5: v = 4 * ((d >= (longint'(1) << (inW-1))) ? d - (longint'(1) << inW) : d);
            default: begin v = 0; err = 1'b1; end
        endcase
        v = ((v % full) + full) % full;
        return 32'(v);
    endfunction

    // Present one input to instance sel, wait (bounded) for acceptance, and log the expectation
    task automatic applyStimulus(input int sel, input logic [15:0] d, input logic [2:0] m,
                                 input logic [31:0] ed, input logic ee);
        bit   accepted;
        logic rdy;
        exp_t e;
        accepted = 1'b0;
        if (sel == 0) begin
            busA.data_i = d; busA.mode_i = m; busA.valid_i = 1'b1;
        end else begin
            busB.data_i = d[11:0]; busB.mode_i = m; busB.valid_i = 1'b1;
        end
        for (int n = 0; n < 50 && !accepted; n++) begin
            @(negedge clk);
            rdy = (sel == 0) ? busA.ready_o : busB.ready_o;
            @(posedge clk);
            #1;
            if (rdy) accepted = 1'b1;
        end
        if (sel == 0) busA.valid_i = 1'b0; else busB.valid_i = 1'b0;
        if (accepted) begin
            e.data = ed; e.err = ee; e.acc = cyc; e.lat = latCheck;
            if (sel == 0) qA.push_back(e); else qB.push_back(e);
        end else begin
            checks++;
            failures++;
            $display("[TB] FAIL accept timeout on dut %0d: got no ready_o, expected acceptance", sel);
        end
    endtask

    // Wait (bounded) for both scoreboards to empty
    task automatic drainWait(input string name);
        for (int n = 0; n < 200 && (qA.size() != 0 || qB.size() != 0); n++) @(posedge clk);
        #1;
        checkOutput({name, " scoreboard A empty"}, qA.size(), 0);
        checkOutput({name, " scoreboard B empty"}, qB.size(), 0);
    endtask

    // Monitor A: compare each output transfer against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && busA.valid_o && busA.ready_i) begin
            if (qA.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL A spurious output: got 0x%0h, expected none", busA.data_o);
            end else begin
                e = qA.pop_front();
                checkOutput("A data", busA.data_o, e.data);
                checkOutput("A err", {31'd0, busA.err_o}, {31'd0, e.err});
                if (e.lat) checkOutput("A latency cycle", cyc, e.acc);
                popsA++;
            end
        end
        if (tpPhase && !busA.ready_o) tpDrops++;
    end

    // Monitor B: same scoreboard check for the narrow instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst && busB.valid_o && busB.ready_i) begin
            if (qB.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL B spurious output: got 0x%0h, expected none", busB.data_o);
            end else begin
                e = qB.pop_front();
                checkOutput("B data", {8'd0, busB.data_o}, e.data);
                checkOutput("B err", {31'd0, busB.err_o}, {31'd0, e.err});
                if (e.lat) checkOutput("B latency cycle", cyc, e.acc);
                popsB++;
            end
        end
    end

    // Random downstream stalls on A during the mixed-traffic phase
    always @(posedge clk) begin
        if (rndPhase) begin
            #1;
            busA.ready_i = 1'($urandom_range(0, 1));
        end
    end

    // Hard stop if anything hangs
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] sd[8];
        logic [2:0]  sm[8];
        logic [31:0] se[8];
        logic [15:0] bd[7];
        logic [2:0]  bm[7];
        logic [31:0] be[7];
        logic        er;
        logic [31:0] ex;
        logic [15:0] rd;
        logic [2:0]  rm;
        int          base;
        int          seen;

        busA.data_i = '0; busA.mode_i = '0; busA.valid_i = 1'b0; busA.ready_i = 1'b1;
        busB.data_i = '0; busB.mode_i = '0; busB.valid_i = 1'b0; busB.ready_i = 1'b1;

        // Power-on reset
        rst = 1'b1;
        #12;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset valid_o", {31'd0, busA.valid_o}, 32'd0);
        checkOutput("reset data_o", busA.data_o, 32'd0);
        checkOutput("reset err_o", {31'd0, busA.err_o}, 32'd0);
        checkOutput("reset ready_o", {31'd0, busA.ready_o}, 32'd1);
        @(posedge clk);
        #1;

        // Mode sweep on the 16->32 instance, one input per cycle, reserved mode included
        sd = '{16'h8001, 16'h8001, 16'h8001, 16'h00F0, 16'h00F0, 16'hFFFF, 16'h1234, 16'h0001};
        sm = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
        se = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFFFFF0,
               32'h000000F0, 32'hFFFFFFFC, 32'h00000000, 32'h00000001};
        latCheck = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(0, sd[i], sm[i], se[i], (sm[i] == 3'd6));
        drainWait("mode sweep A");

        // Same sweep idea on the 12->24 instance
        bd = '{16'h0800, 16'h0ABC, 16'h0001, 16'h00F0, 16'h00F0, 16'h0800, 16'h0123};
        bm = '{3'd0, 3'd2, 3'd5, 3'd3, 3'd4, 3'd1, 3'd7};
        be = '{32'h00FFF800, 32'h00ABC000, 32'h00000004, 32'h00FFFFF0,
               32'h000000F0, 32'h00000800, 32'h00000000};
        for (int i = 0; i < 7; i++) applyStimulus(1, bd[i], bm[i], be[i], (bm[i] == 3'd7));
        drainWait("mode sweep B");

        // Backpressure: A held in OR, B in skid, C refused until the stall clears
        latCheck = 1'b0;
        busA.ready_i = 1'b0;
        base = popsA;
        applyStimulus(0, 16'h0001, 3'd0, 32'h00000001, 1'b0);
        applyStimulus(0, 16'h0002, 3'd0, 32'h00000002, 1'b0);
        @(negedge clk);
        checkOutput("stall ready_o low", {31'd0, busA.ready_o}, 32'd0);
        checkOutput("stall valid_o", {31'd0, busA.valid_o}, 32'd1);
        checkOutput("stall head data", busA.data_o, 32'h00000001);
        @(posedge clk);
        #1;
        fork
            applyStimulus(0, 16'h0003, 3'd0, 32'h00000003, 1'b0);
            begin
                repeat (3) @(negedge clk);
                checkOutput("stall hold data", busA.data_o, 32'h00000001);
                checkOutput("stall C refused", {31'd0, busA.ready_o}, 32'd0);
                @(posedge clk);
                #1;
                busA.ready_i = 1'b1;
            end
        join
        drainWait("backpressure");
        checkOutput("backpressure output count", popsA - base, 3);

        // Throughput: 100 back-to-back random inputs with no stalls
        latCheck = 1'b1;
        base = popsA;
        tpDrops = 0;
        tpPhase = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rd = 16'($urandom);
            rm = 3'($urandom_range(0, 7));
            ex = model(longint'(rd), int'(rm), 16, 32, er);
            applyStimulus(0, rd, rm, ex, er);
        end
        tpPhase = 1'b0;
        drainWait("throughput");
        checkOutput("throughput ready_o drops", tpDrops, 0);
        checkOutput("throughput output count", popsA - base, 100);

        // Mixed traffic with random stalls on A, random traffic on B
        latCheck = 1'b0;
        base = popsA;
        rndPhase = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rd = 16'($urandom);
            rm = 3'($urandom_range(0, 7));
            ex = model(longint'(rd), int'(rm), 16, 32, er);
            applyStimulus(0, rd, rm, ex, er);
            rd = 16'($urandom_range(0, 4095));
            ex = model(longint'(rd), int'(rm), 12, 24, er);
            applyStimulus(1, rd, rm, ex, er);
        end
        rndPhase = 1'b0;
        @(posedge clk);
        #2;
        busA.ready_i = 1'b1;
        drainWait("random stall");
        checkOutput("random stall output count", popsA - base, 60);

        // Asynchronous reset mid-cycle with two entries held
        busA.ready_i = 1'b0;
        applyStimulus(0, 16'h00AA, 3'd1, 32'h000000AA, 1'b0);
        applyStimulus(0, 16'h00BB, 3'd1, 32'h000000BB, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async reset valid_o", {31'd0, busA.valid_o}, 32'd0);
        checkOutput("async reset data_o", busA.data_o, 32'd0);
        checkOutput("async reset ready_o", {31'd0, busA.ready_o}, 32'd1);
        qA.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        busA.ready_i = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (busA.valid_o) seen++;
        end
        checkOutput("post-reset quiet", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
